// File: rtl/pio_initiator_pkg.sv
// rtl/pio_initiator_pkg.sv - shared widths, FSM states and command record for the PIO initiator
package pio_initiator_pkg;

    localparam int PIO_NBITS = 20;
    localparam int CMD_WIDTH = 1 + 2 * PIO_NBITS;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_ISSUE         = 2'd1,
        ST_WAIT_ACK      = 2'd2,
        ST_WAIT_DEASSERT = 2'd3
    } pio_state_t;

    typedef struct packed {
        logic                 wr;
        logic [PIO_NBITS-1:0] addr;
        logic [PIO_NBITS-1:0] wdata;
    } pio_cmd_t;

endpackage

// File: rtl/pio_cmd_fifo.sv
// rtl/pio_cmd_fifo.sv - synchronous command FIFO with registered occupancy
module pio_cmd_fifo #(
    parameter int WIDTH       = 41,
    parameter int DEPTH_NBITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam logic [DEPTH_NBITS:0] DEPTH = {1'b1, {DEPTH_NBITS{1'b0}}};

    logic [WIDTH-1:0]       mem [0:(1<<DEPTH_NBITS)-1];
    logic [DEPTH_NBITS-1:0] wr_ptr;
    logic [DEPTH_NBITS-1:0] rd_ptr;
    logic [DEPTH_NBITS:0]   count;
    logic                   do_push;
    logic                   do_pop;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pio_initiator.sv
// rtl/pio_initiator.sv - queues local read/write commands and runs them one at a time on the PIO bus
module pio_initiator
    import pio_initiator_pkg::*;
#(
    parameter int FIFO_DEPTH_NBITS = 2,
    parameter int TIMEOUT_NBITS    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_wr,
    input  logic [PIO_NBITS-1:0] cmd_addr,
    input  logic [PIO_NBITS-1:0] cmd_wdata,
    output logic [PIO_NBITS-1:0] reg_addr,
    output logic [PIO_NBITS-1:0] reg_din,
    output logic                 reg_rd,
    output logic                 reg_wr,
    output logic                 reg_ms,
    input  logic                 mem_ack,
    input  logic [PIO_NBITS-1:0] mem_rdata,
    output logic                 rsp_valid,
    output logic [PIO_NBITS-1:0] rsp_rdata,
    output logic                 rsp_timeout,
    output logic                 busy,
    output logic [7:0]           timeout_cnt
);

    pio_state_t             state;
    pio_cmd_t               cmd_in;
    pio_cmd_t               head;
    logic [CMD_WIDTH-1:0]   head_bits;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   op_wr;
    logic [TIMEOUT_NBITS-1:0] timer;

    assign cmd_in    = '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
    assign head      = pio_cmd_t'(head_bits);
    assign cmd_ready = !fifo_full;
    assign busy      = (state != ST_IDLE) || !fifo_empty;
    // A still-high ack from an earlier (or reset-aborted) transaction blocks the next issue.
    assign pop       = (state == ST_IDLE) && !fifo_empty && !mem_ack;

    pio_cmd_fifo #(
        .WIDTH       (CMD_WIDTH),
        .DEPTH_NBITS (FIFO_DEPTH_NBITS)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && cmd_ready),
        .wdata (CMD_WIDTH'(cmd_in)),
        .pop   (pop),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            reg_addr    <= '0;
            reg_din     <= '0;
            reg_rd      <= 1'b0;
            reg_wr      <= 1'b0;
            reg_ms      <= 1'b0;
            op_wr       <= 1'b0;
            timer       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            reg_rd      <= 1'b0;
            reg_wr      <= 1'b0;
            reg_ms      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        reg_addr <= head.addr;
                        reg_din  <= head.wdata;
                        op_wr    <= head.wr;
                        reg_ms   <= 1'b1;
                        reg_wr   <= head.wr;
                        reg_rd   <= !head.wr;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (mem_ack) begin
                        rsp_valid <= 1'b1;
                        rsp_rdata <= op_wr ? '0 : mem_rdata;
                        state     <= ST_WAIT_DEASSERT;
                    end else if (&timer) begin
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        if (timeout_cnt != 8'hFF) begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                        state <= ST_WAIT_DEASSERT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_WAIT_DEASSERT: begin
                    if (!mem_ack) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_initiator.sv
// tb/tb_pio_initiator.sv - directed bench with a transaction-level model of the PIO initiator
module tb_pio_initiator;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [19:0] cmd_addr;
    logic [19:0] cmd_wdata;
    logic [19:0] reg_addr;
    logic [19:0] reg_din;
    logic        reg_rd;
    logic        reg_wr;
    logic        reg_ms;
    logic        mem_ack;
    logic [19:0] mem_rdata;
    logic        rsp_valid;
    logic [19:0] rsp_rdata;
    logic        rsp_timeout;
    logic        busy;
    logic [7:0]  timeout_cnt;

    pio_initiator dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .reg_addr(reg_addr), .reg_din(reg_din), .reg_rd(reg_rd), .reg_wr(reg_wr),
        .reg_ms(reg_ms), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .busy(busy), .timeout_cnt(timeout_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_fail = 0;
    int cyc = 0;

    // Responder knobs and state
    bit          resp_en = 1'b1;
    int          resp_delay = 3;
    int          resp_width = 1;
    bit          ack_force = 1'b0;
    logic [19:0] resp_mem [0:255];
    logic [19:0] r_addr;
    bit          r_wr;
    bit          r_active = 1'b0;
    int          r_start = 0;
    bit          win;

    // Reference model state
    logic [40:0] exp_q[$];
    logic [19:0] ref_mem [0:255];
    bit          pending = 1'b0;
    int          exp_cyc = 0;
    logic [19:0] exp_rdata;
    bit          exp_to;
    int          model_tc = 0;
    bit          prev_ack = 1'b0;
    int          n_strobes = 0;
    int          n_rsp = 0;
    int          last_push_cyc = 0;
    int          last_strobe_cyc = 0;
    int          prev_strobe_cyc = 0;
    int          last_rsp_cyc = 0;
    logic [19:0] last_rsp_rdata;
    bit          last_rsp_to;

    task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Responder: a simple memory that raises mem_ack resp_delay cycles after a strobe for resp_width cycles.
    initial begin
        mem_ack = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) resp_mem[i] = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (reg_ms) begin
                r_addr = reg_addr;
                r_wr = reg_wr;
                if (reg_wr && resp_en) resp_mem[reg_addr[7:0]] = reg_din;
                r_start = cyc + resp_delay;
                r_active = resp_en;
            end
            win = r_active && cyc >= r_start && cyc < r_start + resp_width;
            if (r_active && cyc >= r_start + resp_width) r_active = 1'b0;
            mem_ack = ack_force | win;
            mem_rdata = (win && !r_wr) ? resp_mem[r_addr[7:0]] : 20'($urandom);
        end
    end

    // Compare process: every strobe must be the next queued command; every response must land on the
    // cycle and with the data the transaction rules predict.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            pending = 1'b0;
            model_tc = 0;
            prev_ack = mem_ack;
        end else begin
            if (reg_ms || reg_rd || reg_wr) begin
                logic [40:0] h;
                n_strobes++;
                chk_eq("strobe_shape", {30'd0, reg_ms, reg_rd ^ reg_wr}, 32'd3);
                chk_eq("strobe_after_stale_ack", {31'd0, prev_ack}, 32'd0);
                chk_eq("strobe_overlap", {31'd0, pending}, 32'd0);
                chk_eq("strobe_expected", exp_q.size(), 32'(exp_q.size() > 0 ? exp_q.size() : 1));
                if (exp_q.size() > 0) begin
                    h = exp_q.pop_front();
                    chk_eq("strobe_wr", {31'd0, reg_wr}, {31'd0, h[40]});
                    chk_eq("strobe_addr", {12'd0, reg_addr}, {12'd0, h[39:20]});
                    chk_eq("strobe_din", {12'd0, reg_din}, {12'd0, h[19:0]});
                    if (resp_en && resp_delay <= 16) begin
                        exp_cyc = cyc + resp_delay + 1;
                        exp_to = 1'b0;
                        exp_rdata = h[40] ? 20'd0 : ref_mem[h[27:20]];
                        if (h[40]) ref_mem[h[27:20]] = h[19:0];
                    end else begin
                        exp_cyc = cyc + 17;
                        exp_to = 1'b1;
                        exp_rdata = 20'd0;
                    end
                    pending = 1'b1;
                end
                prev_strobe_cyc = last_strobe_cyc;
                last_strobe_cyc = cyc;
            end
            if (rsp_valid) begin
                n_rsp++;
                chk_eq("rsp_expected", {31'd0, pending}, 32'd1);
                if (pending) begin
                    chk_eq("rsp_cycle", cyc, exp_cyc);
                    chk_eq("rsp_rdata", {12'd0, rsp_rdata}, {12'd0, exp_rdata});
                    chk_eq("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, exp_to});
                    if (exp_to && model_tc < 255) model_tc++;
                    pending = 1'b0;
                end
                last_rsp_cyc = cyc;
                last_rsp_rdata = rsp_rdata;
                last_rsp_to = rsp_timeout;
            end else if (pending && cyc >= exp_cyc) begin
                chk_eq("rsp_missing", {31'd0, rsp_valid}, 32'd1);
                pending = 1'b0;
            end
            chk_eq("timeout_cnt", {24'd0, timeout_cnt}, 32'(model_tc));
            prev_ack = mem_ack;
        end
    end

    task automatic push(input bit wr, input logic [19:0] a, input logic [19:0] d);
        bit done = 1'b0;
        cmd_valid = 1'b1;
        cmd_wr = wr;
        cmd_addr = a;
        cmd_wdata = d;
        for (int i = 0; i < 400 && !done; i++) begin
            if (cmd_ready) begin
                exp_q.push_back({wr, a, d});
                last_push_cyc = cyc;
                done = 1'b1;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!done) chk_eq("push_accept", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int lim);
        bit ok = 1'b0;
        for (int i = 0; i < lim && !ok; i++) begin
            @(negedge clk);
            if (!busy && !pending && exp_q.size() == 0 && !mem_ack) ok = 1'b1;
        end
        if (!ok) chk_eq("idle_wait", 32'd0, 32'd1);
    endtask

    int s0;
    int r0;
    bit seen;

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr = 1'b0;
        cmd_addr = '0;
        cmd_wdata = '0;
        repeat (3) @(negedge clk);
        chk_eq("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk_eq("reset_outputs", {reg_rd, reg_wr, reg_ms, rsp_valid, rsp_timeout, busy},
               32'd0);
        chk_eq("reset_addr_din", {reg_addr, reg_din[11:0]} | {20'd0, reg_din[19:12], 4'd0}, 32'd0);
        chk_eq("reset_rsp_rdata", {12'd0, rsp_rdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single write, ack 3 cycles after strobe
        push(1'b1, 20'h10, 20'hABCDE);
        wait_idle(200);
        chk_eq("wr_strobe_latency", last_strobe_cyc, last_push_cyc + 2);
        chk_eq("wr_rsp_latency", last_rsp_cyc, last_strobe_cyc + 4);
        chk_eq("wr_rsp_rdata", {12'd0, last_rsp_rdata}, 32'd0);
        chk_eq("wr_rsp_timeout", {31'd0, last_rsp_to}, 32'd0);

        // Write then read back
        s0 = n_strobes;
        push(1'b1, 20'h20, 20'h005A5);
        push(1'b0, 20'h20, 20'h0);
        wait_idle(200);
        chk_eq("wr_rd_strobes", n_strobes - s0, 32'd2);
        chk_eq("rd_back_rdata", {12'd0, last_rsp_rdata}, 32'h005A5);

        // Fill the FIFO while a stale ack holds the FSM in IDLE
        ack_force = 1'b1;
        repeat (2) @(negedge clk);
        s0 = n_strobes;
        push(1'b1, 20'h30, 20'h000A1);
        push(1'b1, 20'h31, 20'h000B2);
        push(1'b0, 20'h30, 20'h0);
        push(1'b0, 20'h31, 20'h0);
        chk_eq("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        chk_eq("full_no_strobe", n_strobes - s0, 32'd0);
        chk_eq("full_busy", {31'd0, busy}, 32'd1);
        ack_force = 1'b0;
        push(1'b0, 20'h20, 20'h0);
        wait_idle(400);
        chk_eq("five_strobes", n_strobes - s0, 32'd5);
        chk_eq("fifth_rdata", {12'd0, last_rsp_rdata}, 32'h005A5);

        // Ack held high for 10 cycles
        resp_width = 10;
        r0 = n_rsp;
        push(1'b0, 20'h10, 20'h0);
        push(1'b0, 20'h31, 20'h0);
        wait_idle(400);
        resp_width = 1;
        chk_eq("held_ack_rsps", n_rsp - r0, 32'd2);
        chk_eq("held_ack_spacing", last_strobe_cyc - prev_strobe_cyc, 32'd15);
        chk_eq("held_ack_rdata", {12'd0, last_rsp_rdata}, 32'h000B2);

        // No responder: timeouts and saturation
        resp_en = 1'b0;
        push(1'b0, 20'h40, 20'h0);
        wait_idle(200);
        chk_eq("to_latency", last_rsp_cyc, last_strobe_cyc + 17);
        chk_eq("to_flag", {31'd0, last_rsp_to}, 32'd1);
        chk_eq("to_rdata", {12'd0, last_rsp_rdata}, 32'd0);
        chk_eq("to_cnt_one", {24'd0, timeout_cnt}, 32'd1);
        for (int i = 0; i < 256; i++) push(1'b0, 20'h40, 20'h0);
        wait_idle(1000);
        chk_eq("to_cnt_sat", {24'd0, timeout_cnt}, 32'd255);

        // Reset while waiting for ack with two commands still queued
        resp_en = 1'b1;
        resp_delay = 8;
        push(1'b0, 20'h10, 20'h0);
        push(1'b0, 20'h20, 20'h0);
        push(1'b0, 20'h30, 20'h0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (pending) seen = 1'b1;
            else @(negedge clk);
        end
        chk_eq("rst_strobe_seen", {31'd0, seen}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s0 = n_strobes;
        r0 = n_rsp;
        repeat (20) @(negedge clk);
        chk_eq("rst_no_strobes", n_strobes - s0, 32'd0);
        chk_eq("rst_no_rsp", n_rsp - r0, 32'd0);
        chk_eq("rst_busy", {31'd0, busy}, 32'd0);
        chk_eq("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk_eq("rst_timeout_cnt", {24'd0, timeout_cnt}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_initiator.md
# pio_initiator

PIO bus initiator: accepts read/write commands from a local agent through a small command FIFO and executes them one at a time on the PIO register/memory bus (reg_ms/reg_rd/reg_wr strobes, mem_ack/mem_rdata return). It drives PIO-accessible memories and register blocks: it waits for the responder's ack to rise and fall, returns read data, and flags transactions that time out. It sits between firmware-facing command logic and the PIO fabric.

## Interface
- FIFO_DEPTH_NBITS, 2, log2 of command FIFO depth (4 entries)
- TIMEOUT_NBITS, 4, ack timeout counter width; timeout after 2^TIMEOUT_NBITS cycles in WAIT_ACK
---
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full; push when cmd_valid&cmd_ready
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  `PIO_RANGE  byte address, passed unmodified
- cmd_wdata  in  `PIO_RANGE  write data
- reg_addr  out  `PIO_RANGE  transaction address
- reg_din  out  `PIO_RANGE  write data
- reg_rd  out  1  read strobe
- reg_wr  out  1  write strobe
- reg_ms  out  1  memory select strobe
- mem_ack  in  1  responder ack (level; held until responder clears it)
- mem_rdata  in  `PIO_RANGE  read data, valid while mem_ack high
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  `PIO_RANGE  read data; 0 for writes and timeouts
- rsp_timeout  out  1  qualifies rsp_valid: transaction timed out
- busy  out  1  FSM not IDLE or FIFO not empty
- timeout_cnt  out  8  saturating count of timeouts

## Operation
- Reset values: all outputs 0 except cmd_ready=1; FIFO empty; FSM IDLE; timer 0.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DEASSERT.
- IDLE: if FIFO non-empty and mem_ack=0 -> pop head, latch into reg_addr/reg_din/op -> ISSUE. If mem_ack=1, stay (stale ack guard).
- ISSUE: reg_ms=1 and reg_wr=op or reg_rd=~op, exactly one cycle -> WAIT_ACK, timer cleared.
- WAIT_ACK: timer increments every cycle. mem_ack=1 -> capture mem_rdata (reads) or 0 (writes), rsp_valid=1, rsp_timeout=0 next cycle -> WAIT_DEASSERT. Timer reaches all-ones with mem_ack=0 -> rsp_valid=1, rsp_timeout=1, rsp_rdata=0, timeout_cnt+1 (saturates at 255) -> WAIT_DEASSERT. Ack wins if both occur in the same cycle.
- WAIT_DEASSERT: mem_ack=0 -> IDLE.
- reg_addr/reg_din hold their value from ISSUE until the next pop; strobes low in every state except ISSUE.
- FIFO: cmd_ready=~full; simultaneous push and pop keeps occupancy; push while full is impossible (ready low); commands execute in order.
- Reset mid-transaction: FSM to IDLE, FIFO flushed, no rsp_valid; any responder ack still pending is absorbed by the IDLE mem_ack guard.

## Timing
- Push at cycle t into empty FIFO, IDLE, mem_ack low: strobes high at cycle t+2.
- mem_ack first sampled high at cycle a: rsp_valid at a+1.
- Timeout: strobe at cycle s, mem_ack low throughout -> rsp_valid with rsp_timeout at s+1+2^TIMEOUT_NBITS (s+17 at default).
- Minimum back-to-back spacing: strobe-to-strobe >= 4 cycles (ISSUE, WAIT_ACK, WAIT_DEASSERT, IDLE) when ack is 1-cycle wide.
- All outputs registered; no combinational path from mem_ack to strobes.

## Structure
- FSM state encodings (`PIO_INIT_ST_IDLE/ISSUE/WAIT_ACK/WAIT_DEASSERT) go in defines.vh next to `PIO_RANGE/`PIO_NBITS.
- One sub-module: pio_cmd_fifo (synchronous, registered, WIDTH = 1+2*`PIO_NBITS, depth 2^FIFO_DEPTH_NBITS, full/empty outputs).

## Test plan
- Single write addr 0x10 data 0xABCDE, responder acks 3 cycles after strobe -> one reg_ms&reg_wr pulse at t+2 with reg_addr=0x10, rsp_valid with rdata 0, timeout 0.
- Write 0x5A5 to 0x20 then read 0x20 against pio_mem_ultra (WIDTH=20) -> read rsp_rdata=0x005A5, exactly two strobe pulses in order.
- Four pushes back-to-back then fifth -> cmd_ready low after 4th until first pop; all five complete in order, no drops.
- No responder: read 0x40 -> rsp_valid with rsp_timeout=1, rdata 0, at strobe+17; timeout_cnt=1; 256 timeouts -> timeout_cnt stays 255.
- Responder holds mem_ack high 10 cycles -> single rsp_valid; next strobe not issued until mem_ack low.
- rst asserted in WAIT_ACK with 2 queued commands, responder acks after reset -> no rsp_valid, no strobes, FIFO empty, busy=0, cmd_ready=1.
